writeback_unit: RTL

//  Writeback stage feeding register_file write port (write_enable/write_addr/write_data).

---
 rtl/writeback_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and FIFO-buffered load results onto the register-file write port.
// Define WB_BYPASS_EN to add the combinational forwarding outputs fwd_valid/fwd_addr/fwd_data.
module writeback_unit #(
  parameter int unsigned LQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_data,
  input  logic        issue_valid,
  input  logic [2:0]  issue_rd,
  output logic [7:0]  pending,
  output logic        write_enable,
  output logic [2:0]  write_addr,
  output logic [15:0] write_data,
  output logic        protocol_err
`ifdef WB_BYPASS_EN
  ,
  output logic        fwd_valid,
  output logic [2:0]  fwd_addr,
  output logic [15:0] fwd_data
`endif
);

  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C       = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STARVE_LAST_C = SW'(STARVE_LIMIT - 1);

  logic [2:0]    lq_rd_q   [LQ_DEPTH];
  logic [15:0]   lq_data_q [LQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic [7:0]    pend_q, pend_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [2:0]    waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;

  logic          alu_take, fifo_ne, pop, push, sel_valid;
  logic [2:0]    sel_rd;
  logic [15:0]   sel_data;

  assign mem_ready    = (count_q < DEPTH_C) & ~reset;
  assign alu_stall    = stall_q;
  assign pending      = pend_q;
  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign protocol_err = err_q;

  // Only entries present at the start of the cycle may be popped, so a load
  // spends at least one full cycle in the FIFO before it is written back.
  always_comb begin
    alu_take  = alu_valid & ~stall_q;
    fifo_ne   = (count_q != '0);
    pop       = ~alu_take & fifo_ne;
    push      = mem_valid & mem_ready;
    sel_valid = alu_take | pop;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_take) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (pop) begin
      sel_rd   = lq_rd_q[rd_ptr_q];
      sel_data = lq_data_q[rd_ptr_q];
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = sel_valid & (sel_rd != '0);
  assign fwd_addr  = sel_rd;
  assign fwd_data  = sel_data;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    stall_d  = 1'b0;
    starve_d = '0;
    if (alu_take && fifo_ne) begin
      if (starve_q == STARVE_LAST_C) stall_d  = 1'b1;
      else                           starve_d = starve_q + SW'(1);
    end

    we_d    = sel_valid & (sel_rd != '0);
    waddr_d = sel_rd;
    wdata_d = sel_data;

    // Set is applied after clear so a same-cycle reissue keeps the bit set.
    pend_d = pend_q;
    if (pop && sel_rd != '0)                pend_d[sel_rd]   = 1'b0;
    if (issue_valid && issue_rd != '0)      pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    err_d = err_q
          | (alu_valid & stall_q)
          | (issue_valid & (issue_rd != '0) & pend_q[issue_rd])
          | (alu_valid & pend_q[alu_rd])
          | (push & ~pend_q[mem_rd]);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q]   <= mem_rd;
      lq_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
